// File: rtl/rv32i_types.sv
// Shared types for the dmem responder: FSM state encoding, lane count, request bundle.
// No logic; imported by the responder and its storage array.
// No flow control of its own.
package rv32i_types;

    localparam int MEM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_rsp_state_t;

    typedef struct packed {
        logic [31:0]          addr;
        logic [MEM_LANES-1:0] rmask;
        logic [MEM_LANES-1:0] wmask;
        logic [31:0]          wdata;
    } dmem_req_t;

endpackage

// File: rtl/mem_byte_array.sv
// Word-organized, byte-writable storage: 2^ADDR_WIDTH words of MEM_LANES bytes.
// Write takes effect at the clock edge; read is combinational.
// No backpressure; contents are never reset.
module mem_byte_array
    import rv32i_types::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] widx,
    input  logic                  we,
    input  logic [MEM_LANES-1:0]  be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [MEM_LANES-1:0][7:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MEM_LANES; i++) begin
                if (be[i]) mem[widx][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[widx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side dmem responder: one request at a time against a local byte-writable array.
// Latency: dmem_resp pulses exactly LATENCY cycles after the request first appears.
// Backpressure: CPU holds the request until dmem_resp; at least one idle cycle between accesses.
module dmem_responder
    import rv32i_types::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1eceb000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       SINGLE   = (LATENCY == 1);

    dmem_rsp_state_t state;
    logic [3:0]      cnt;
    dmem_req_t       req_q;
    dmem_req_t       live;
    dmem_req_t       cur;

    logic            req_vld;
    logic [29:0]     word_addr;
    logic [29:0]     word_off;
    logic            in_range;
    logic            is_read;
    logic            is_write;
    logic            acc_err;
    logic            fire;
    logic            arr_we;
    logic [31:0]     arr_rdata;
    logic            unused_addr_bits;

    assign live    = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};
    assign req_vld = (dmem_rmask | dmem_wmask) != 4'd0;

    // In IDLE the live inputs are decoded so a LATENCY==1 access can complete at the capture edge.
    assign cur = (state == IDLE) ? live : req_q;

    // Word-granular compare: the subtraction only means something when addr >= BASE_ADDR.
    assign word_addr        = cur.addr[31:2];
    assign word_off         = word_addr - BASE_ADDR[31:2];
    assign in_range         = (word_addr >= BASE_ADDR[31:2]) &&
                              (({2'b00, word_off} >> ADDR_WIDTH) == 32'd0);
    assign unused_addr_bits = ^cur.addr[1:0];

    assign is_read  = (cur.rmask != 4'd0);
    assign is_write = (cur.wmask != 4'd0);
    assign acc_err  = !in_range || (is_read && is_write);

    assign fire   = ((state == IDLE) && req_vld && SINGLE) || ((state == BUSY) && (cnt == 4'd0));
    assign arr_we = rst_n && fire && is_write && !acc_err;

    mem_byte_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .widx  (word_off[ADDR_WIDTH-1:0]),
        .we    (arr_we),
        .be    (cur.wmask),
        .wdata (cur.wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_q      <= '0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= 32'd0;
        end else begin
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        req_q <= live;
                        if (SINGLE) begin
                            state <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (fire) begin
                dmem_resp  <= 1'b1;
                dmem_err   <= acc_err;
                dmem_rdata <= (is_read && !acc_err) ? arr_rdata : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1, 3 and 15 with a scoreboard of expected responses.
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'h1eceb000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_a  [4];
    logic [3:0]  rmask_a [4];
    logic [3:0]  wmask_a [4];
    logic [31:0] wdata_a [4];
    logic [31:0] rdata_w [4];
    logic        resp_w  [4];
    logic        err_w   [4];

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr_a[0]), .dmem_rmask(rmask_a[0]),
        .dmem_wmask(wmask_a[0]), .dmem_wdata(wdata_a[0]), .dmem_rdata(rdata_w[0]),
        .dmem_resp(resp_w[0]), .dmem_err(err_w[0]));
    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr_a[1]), .dmem_rmask(rmask_a[1]),
        .dmem_wmask(wmask_a[1]), .dmem_wdata(wdata_a[1]), .dmem_rdata(rdata_w[1]),
        .dmem_resp(resp_w[1]), .dmem_err(err_w[1]));
    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr_a[2]), .dmem_rmask(rmask_a[2]),
        .dmem_wmask(wmask_a[2]), .dmem_wdata(wdata_a[2]), .dmem_rdata(rdata_w[2]),
        .dmem_resp(resp_w[2]), .dmem_err(err_w[2]));
    dmem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .LATENCY(15)) u_l15 (
        .clk(clk), .rst_n(rst_n), .dmem_addr(addr_a[3]), .dmem_rmask(rmask_a[3]),
        .dmem_wmask(wmask_a[3]), .dmem_wdata(wdata_a[3]), .dmem_rdata(rdata_w[3]),
        .dmem_resp(resp_w[3]), .dmem_err(err_w[3]));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs(input int k);
        addr_a[k]  = 32'd0;
        rmask_a[k] = 4'd0;
        wmask_a[k] = 4'd0;
        wdata_a[k] = 32'd0;
    endtask

    // Drives one request on instance k, counts cycles to resp, and checks against the scoreboard.
    task automatic run_req(input int k, input string tag, input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] er,
                           input logic ee, input bit disturb);
        int   cyc;
        exp_t e;
        @(negedge clk);
        addr_a[k]  = a;
        rmask_a[k] = rm;
        wmask_a[k] = wm;
        wdata_a[k] = wd;
        exp_q.push_back('{rdata: er, err: ee});
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (disturb && cyc == 1) begin
                addr_a[k]  = BASE + 32'h80;
                wdata_a[k] = ~wd;
            end
        end while (!resp_w[k] && cyc < 40);
        chk({tag, " resp_seen"}, 32'(resp_w[k]), 32'd1);
        chk({tag, " latency"}, cyc, lat_of(k));
        idle_inputs(k);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, " rdata"}, rdata_w[k], e.rdata);
            chk({tag, " err"}, 32'(err_w[k]), 32'(e.err));
        end else begin
            chk({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        chk({tag, " pulse_end"}, {rdata_w[k][30:0], resp_w[k] | err_w[k]}, 32'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) idle_inputs(k);
        #3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_resp%0d", k), 32'(resp_w[k]), 32'd0);
            chk($sformatf("reset_rdata%0d", k), rdata_w[k], 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, byte write, misaligned and mask-conflict handling at LATENCY 2
        run_req(0, "wr_full",  BASE + 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        run_req(0, "rd_full",  BASE + 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        run_req(0, "wr_byte2", BASE + 32'h10, 4'h0, 4'b0100, 32'h00AA0000, 32'h0, 1'b0, 1'b0);
        run_req(0, "rd_byte2", BASE + 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 1'b0);
        run_req(0, "wr_w0",    BASE,          4'h0, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b0);
        run_req(0, "wr_last",  BASE + 32'hFFC, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        run_req(0, "rd_below", BASE - 32'h4,  4'hF, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        run_req(0, "rd_above", BASE + 32'h1000, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        run_req(0, "wr_below", BASE - 32'h4,  4'h0, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        run_req(0, "wr_above", BASE + 32'h1000, 4'h0, 4'hF, 32'hEEEEEEEE, 32'h0, 1'b1, 1'b0);
        run_req(0, "rd_w0",    BASE,          4'hF, 4'h0, 32'h0, 32'h12345678, 1'b0, 1'b0);
        run_req(0, "rd_last",  BASE + 32'hFFC, 4'hF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        run_req(0, "rw_both",  BASE + 32'h10, 4'hF, 4'h1, 32'h000000FF, 32'h0, 1'b1, 1'b0);
        run_req(0, "rd_nowr",  BASE + 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 1'b0);
        run_req(0, "rd_mis3",  BASE + 32'h13, 4'h1, 4'h0, 32'h0, 32'hDEAABEEF, 1'b0, 1'b0);
        run_req(0, "wr_mis1",  BASE + 32'h11, 4'h0, 4'h1, 32'h00000011, 32'h0, 1'b0, 1'b0);
        run_req(0, "rd_mis1",  BASE + 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAABE11, 1'b0, 1'b0);

        // Latency sweep, back-to-back with one idle gap
        run_req(1, "l1_wr", BASE + 32'h20, 4'h0, 4'hF, 32'h01020304, 32'h0, 1'b0, 1'b0);
        run_req(1, "l1_rd", BASE + 32'h20, 4'b0010, 4'h0, 32'h0, 32'h01020304, 1'b0, 1'b0);
        run_req(1, "l1_err", BASE - 32'h8, 4'hF, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        run_req(2, "l3_wr", BASE + 32'h30, 4'h0, 4'b1001, 32'h5A0000A5, 32'h0, 1'b0, 1'b0);
        run_req(2, "l3_wr2", BASE + 32'h30, 4'h0, 4'b0110, 32'h00C3C300, 32'h0, 1'b0, 1'b0);
        run_req(2, "l3_rd", BASE + 32'h30, 4'hF, 4'h0, 32'h0, 32'h5AC3C3A5, 1'b0, 1'b0);
        run_req(3, "l15_wr", BASE + 32'h40, 4'h0, 4'hF, 32'hAABBCCDD, 32'h0, 1'b0, 1'b1);
        run_req(3, "l15_rd", BASE + 32'h40, 4'hF, 4'h0, 32'h0, 32'hAABBCCDD, 1'b0, 1'b0);
        run_req(3, "l15_rd80", BASE + 32'h80, 4'h0, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, 1'b0);

        // Reset during BUSY of a write on the LATENCY 15 instance: write is dropped, no resp
        @(negedge clk);
        addr_a[3]  = BASE + 32'h40;
        wmask_a[3] = 4'hF;
        wdata_a[3] = 32'h11111111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy_resp", 32'(resp_w[3]), 32'd0);
        idle_inputs(3);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (resp_w[3]) seen = 1'b1;
        end
        chk("rst_busy_no_resp", 32'(seen), 32'd0);
        run_req(3, "rst_readback", BASE + 32'h40, 4'hF, 4'h0, 32'h0, 32'hAABBCCDD, 1'b0, 1'b0);

        // Reset while resp is high clears outputs without waiting for a clock edge
        @(negedge clk);
        addr_a[0]  = BASE + 32'h10;
        rmask_a[0] = 4'hF;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!resp_w[0] && cyc < 40);
        chk("rst_resp_pre_rdata", rdata_w[0], 32'hDEAABE11);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_resp_async_resp", 32'(resp_w[0]), 32'd0);
        chk("rst_resp_async_rdata", rdata_w[0], 32'd0);
        idle_inputs(0);
        @(negedge clk);
        rst_n = 1'b1;
        run_req(0, "post_rst_rd", BASE + 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEAABE11, 1'b0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
